// File: rtl/jtmx5k_snd_pkg.sv
// Shared definitions for the MX5000 sound output stage: FSM encoding,
// saturation limits, gain fraction width and the 16-bit saturator.
package jtmx5k_snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SUM   = 3'd1,
    ST_DCRM  = 3'd2,
    ST_SCALE = 3'd3,
    ST_SAT   = 3'd4
  } state_t;

  localparam logic [15:0] SAT_MAX   = 16'h7FFF;
  localparam logic [15:0] SAT_MIN   = 16'h8000;
  localparam int unsigned GAIN_FRAC = 4;

  // Returns {clip, value}
  function automatic logic [16:0] sat16(input logic signed [20:0] v);
    logic [16:0] r;
    if (v > 21'sd32767)       r = {1'b1, SAT_MAX};
    else if (v < -21'sd32768) r = {1'b1, SAT_MIN};
    else                      r = {1'b0, 16'(v)};
    return r;
  endfunction

endpackage

// File: rtl/jtmx5k_snd_peak.sv
// Peak/clip LED driver: stays lit PEAK_HOLD clocks after the last clip,
// retriggering on every new clip.
module jtmx5k_snd_peak #(
  parameter logic [23:0] PEAK_HOLD = 24'd2_400_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clip,
  output logic peak
);

  logic [23:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clip)        cnt <= PEAK_HOLD - 24'd1;
    else if (cnt != '0)   cnt <= cnt - 24'd1;
  end

  // The clipping cycle itself counts towards the hold time
  assign peak = (cnt != '0) | clip;

endmodule

// File: rtl/jtmx5k_snd_mix.sv
// MX5000 sound output stage: stereo down-mix, FX-level gain, 16-bit
// saturation and peak LED. Define JTMX5K_DCRM_EN to add a DC-removal stage.
import jtmx5k_snd_pkg::*;

module jtmx5k_snd_mix #(
  parameter logic [23:0] PEAK_HOLD = 24'd2_400_000,
  parameter logic [7:0]  GAIN0     = 8'h08,
  parameter logic [7:0]  GAIN1     = 8'h10,
  parameter logic [7:0]  GAIN2     = 8'h18,
  parameter logic [7:0]  GAIN3     = 8'h20
`ifdef JTMX5K_DCRM_EN
  ,
  parameter int unsigned DCW       = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snd_left,
  input  logic [15:0] snd_right,
  input  logic        sample_in,
  input  logic [1:0]  fxlevel,
  input  logic        mute,
  output logic [15:0] snd,
  output logic        sample,
  output logic        peak,
  output logic        busy
);

  state_t             st, st_nxt;
  logic signed [15:0] l_r, r_r, mono;
  logic signed [20:0] scaled;
  logic signed [24:0] prod;
  logic        [7:0]  gain;
  logic        [16:0] sat_r;
  logic               clip;
`ifdef JTMX5K_DCRM_EN
  logic signed [15:0] x1, y1, dc_y;
  logic signed [19:0] dc_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (sample_in) st_nxt = ST_SUM;
`ifdef JTMX5K_DCRM_EN
      ST_SUM:   st_nxt = ST_DCRM;
      ST_DCRM:  st_nxt = ST_SCALE;
`else
      ST_SUM:   st_nxt = ST_SCALE;
`endif
      ST_SCALE: st_nxt = ST_SAT;
      ST_SAT:   st_nxt = ST_IDLE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (fxlevel)
      2'd0:    gain = GAIN0;
      2'd1:    gain = GAIN1;
      2'd2:    gain = GAIN2;
      default: gain = GAIN3;
    endcase
    prod  = mono * $signed({1'b0, gain});
    sat_r = sat16(scaled);
    clip  = (st == ST_SAT) && !mute && sat_r[16];
`ifdef JTMX5K_DCRM_EN
    dc_raw = 20'(mono) - 20'(x1) + 20'(y1) - (20'(y1) >>> DCW);
    dc_y   = 16'(sat16(21'(dc_raw)));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_r    <= '0;
      r_r    <= '0;
      mono   <= '0;
      scaled <= '0;
      snd    <= '0;
      sample <= 1'b0;
      busy   <= 1'b0;
`ifdef JTMX5K_DCRM_EN
      x1     <= '0;
      y1     <= '0;
`endif
    end else begin
      sample <= 1'b0;
      case (st)
        ST_IDLE: if (sample_in) begin
          l_r  <= snd_left;
          r_r  <= snd_right;
          busy <= 1'b1;
        end
        ST_SUM:   mono <= 16'((17'(l_r) + 17'(r_r)) >>> 1);
`ifdef JTMX5K_DCRM_EN
        ST_DCRM: begin
          x1   <= mono;
          y1   <= dc_y;
          mono <= dc_y;
        end
`endif
        ST_SCALE: scaled <= 21'(prod >>> GAIN_FRAC);
        ST_SAT: begin
          snd    <= mute ? '0 : sat_r[15:0];
          sample <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  jtmx5k_snd_peak #(.PEAK_HOLD(PEAK_HOLD)) u_peak (
    .clk  (clk),
    .rst  (rst),
    .clip (clip),
    .peak (peak)
  );

endmodule

// File: doc/jtmx5k_snd_mix.md
Name: jtmx5k_snd_mix

Overview:
Output stage of the MX5000 sound path. Sits between jtmx5k_sound (signed stereo samples plus a sample strobe) and the game top-level `snd`, `sample` and `game_led` outputs. The block:
- down-mixes left/right to mono;
- applies a gain chosen by the 2-bit FX level setting;
- saturates to 16 bits;
- drives a peak/clip LED with a hold timer.

Parameters:
- PEAK_HOLD, 24'd2_400_000: clk cycles the peak LED stays lit after the last clipped sample (100 ms at 24 MHz).
- GAIN0, 8'h08: gain for fxlevel=0, unsigned 4.4 fixed point (0.5).
- GAIN1, 8'h10: gain for fxlevel=1 (1.0).
- GAIN2, 8'h18: gain for fxlevel=2 (1.5).
- GAIN3, 8'h20: gain for fxlevel=3 (2.0).
- DCW, 4: DC-removal pole shift. Used only when the optional feature is compiled in.

Ports:
- clk, in, 1: system clock, 24 MHz (the clk24 domain of the sound CPU).
- rst, in, 1: reset. Asynchronous, active-high.
- snd_left, in, 16: signed left sample from the sound block.
- snd_right, in, 16: signed right sample from the sound block.
- sample_in, in, 1: one-clk strobe; the left/right pair is valid in this cycle.
- fxlevel, in, 2: gain select (dip_fxlevel).
- mute, in, 1: forces a zero output (driven by dip_pause / downloading).
- snd, out, 16: signed mono output, registered.
- sample, out, 1: one-clk strobe; `snd` was updated in this cycle.
- peak, out, 1: clip indicator, goes to game_led.
- busy, out, 1: the pipeline is processing a sample.

Behaviour:
- Reset (asynchronous): snd=0, sample=0, peak=0, busy=0, hold counter=0, FSM=IDLE, all pipeline registers 0. A reset in mid-operation aborts the sample in flight; no `sample` pulse is produced for it.
- FSM states: IDLE, SUM, SCALE, SAT.
  - IDLE: on sample_in=1, capture L and R, go to SUM, set busy=1.
  - SUM: sum17 = sext(L) + sext(R), 17 bits, no overflow possible. Then mono = sum17 >>> 1 (arithmetic shift, rounds toward −∞). Go to SCALE.
  - SCALE: prod25 = mono (signed 16) × {1'b0, gain} (signed 9); gain is sampled from fxlevel in this cycle. scaled = prod25 >>> 4. Go to SAT.
  - SAT:
    - If scaled > 32767, result is 16'h7FFF with clip=1.
    - If scaled < −32768, result is 16'h8000 with clip=1.
    - Otherwise the result is scaled[15:0] with clip=0.
    - If mute=1, result is 0 and clip=0.
    - Register the result into snd, pulse sample=1 for one clk, set busy=0, return to IDLE.
- Latency: sample_in at cycle N gives snd/sample at cycle N+3.
- A sample_in arriving while busy=1 is dropped: no capture, no extra `sample` pulse. The sample in flight completes unaffected.
- sample_in in the same cycle SAT completes (busy still 1) is also dropped. Back-to-back acceptance is every 4 clks at best.
- Peak timer:
  - On clip=1 in SAT, the counter loads PEAK_HOLD−1 and peak=1.
  - Otherwise, while counter≠0, the counter decrements each clk; peak = (counter≠0) | (clip this cycle).
  - A clip while the counter is nonzero reloads it (retrigger).
  - The counter saturates at 0 and never wraps.
- fxlevel changes take effect on the next SCALE; there is no glitch on the current output.
- mute also clears clip, so a muted sample never triggers peak.

Optional Feature:
- Macro: JTMX5K_DCRM_EN.
- When defined, an extra DCRM state is inserted between SUM and SCALE.
  - One-pole high-pass: y = mono − x1 + y1 − (y1 >>> DCW), computed 20 bits wide with saturation to 16 bits.
  - x1 and y1 update only in DCRM. Both reset to 0.
  - mute does not clear them.
  - Latency becomes 4 clks; the minimum acceptance interval becomes 5 clks.
- When undefined, DCRM is absent and latency is 3 clks.

Decomposition:
- Package jtmx5k_snd_pkg holds:
  - the FSM state encoding (3-bit localparams ST_IDLE, ST_SUM, ST_DCRM, ST_SCALE, ST_SAT);
  - SAT_MAX=16'h7FFF and SAT_MIN=16'h8000;
  - the 4.4 gain fraction width (GAIN_FRAC=4).
- One sub-module, jtmx5k_snd_peak, holds the PEAK_HOLD counter and the peak output. The datapath and FSM stay in the top.

Test Plan:
- Unity mix: fxlevel=1, L=16'h1000, R=16'h2000, strobe → 3 clks later snd=16'h1800, sample pulses once, peak=0.
- Clip: fxlevel=3, L=R=16'h7000 → snd=16'h7FFF, peak=1 for exactly PEAK_HOLD clks (use PEAK_HOLD=16 in sim). With L=R=16'h9000 → snd=16'h8000, peak=1.
- Retrigger: a second clipping sample 10 clks after the first → peak stays high continuously for 10+16 clks.
- Dropped strobe: strobes at N and N+2 → exactly one sample pulse at N+3, snd reflects only the first pair. Strobes at N and N+4 → two pulses, at N+3 and N+7.
- Mute and odd mix: mute=1 with a clipping pair → snd=0, peak stays 0. mute=0, fxlevel=0, L=−1, R=0 → snd=16'hFFFF (−1>>>1=−1; ×8>>>4=−1).
- Reset: assert rst during SCALE → snd=0, sample never pulses, busy=0 immediately. After release, the next strobe processes normally. With JTMX5K_DCRM_EN, a constant input of 16'h1000 decays toward 0 over successive samples.
